// File: rtl/calc_seq_ctrl_pkg.sv
// Shared types for the calculator sequencer: opcodes, FSM states and result-width helper.
package calc_pkg;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Results are twice the operand width so a full product fits.
    function automatic int res_w(input int width);
        return 2 * width;
    endfunction

endpackage

// File: rtl/calc_seq_ctrl_if.sv
// Command and result valid/ready channels between the decoder, sequencer and display formatter.
interface calc_seq_ctrl_if #(
    parameter int WIDTH = 8
) ();
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [WIDTH-1:0]     cmd_a;
    logic [WIDTH-1:0]     cmd_b;
    logic                 res_valid;
    logic                 res_ready;
    logic [2*WIDTH-1:0]   res_data;
    logic                 res_err;

    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        input  cmd_ready, res_valid, res_data, res_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, res_ready,
        output cmd_ready, res_valid, res_data, res_err
    );
endinterface

// File: rtl/calc_seq_ctrl_datapath.sv
// Operand/accumulator/quotient registers around one shared adder-subtractor.
module calc_seq_datapath
    import calc_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clr_i,
    input  logic               load_i,
    input  logic               step_i,
    input  op_e                op_i,
    input  logic [CNT_W-1:0]   cnt_i,
    input  logic               opnd_sel_i,
    input  logic [WIDTH-1:0]   a_i,
    input  logic [WIDTH-1:0]   b_i,
    output logic               mul_next_bit_o,
    output logic               b_zero_o,
    output logic [2*WIDTH-1:0] result_o
);
    localparam int RW = res_w(WIDTH);

    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [RW-1:0]    acc_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;

    logic [WIDTH:0]   rem_sh;
    logic [RW:0]      lhs;
    logic [RW:0]      rhs;
    logic [RW:0]      rhs_sel;
    logic [RW:0]      sum;
    logic             sub;
    logic [WIDTH-1:0] rem_new;
    logic [WIDTH-1:0] quo_new;

    always_comb begin
        rem_sh = {rem_q, a_q[WIDTH-1]};
        sub    = (op_i == OP_SUB) || (op_i == OP_DIV);
        lhs    = '0;
        rhs    = '0;
        case (op_i)
            OP_MUL: begin
                lhs = {1'b0, acc_q};
                rhs = {{(WIDTH+1){1'b0}}, b_q} << cnt_i;
            end
            OP_DIV: begin
                lhs = {{WIDTH{1'b0}}, rem_sh};
                rhs = {{(WIDTH+1){1'b0}}, b_q};
            end
            default: begin
                lhs = {{(WIDTH+1){1'b0}}, a_q};
                rhs = {{(WIDTH+1){1'b0}}, b_q};
            end
        endcase
        rhs_sel = opnd_sel_i ? rhs : '0;
        sum     = lhs + (sub ? ~rhs_sel : rhs_sel) + {{RW{1'b0}}, sub};
        // Top bit of the trial difference is the borrow: set means restore.
        rem_new = sum[RW] ? rem_sh[WIDTH-1:0] : sum[WIDTH-1:0];
        quo_new = {quo_q[WIDTH-2:0], ~sum[RW]};
    end

    assign result_o       = (op_i == OP_DIV) ? {rem_new, quo_new} : sum[RW-1:0];
    assign mul_next_bit_o = a_q[1];
    assign b_zero_o       = (b_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (clr_i) begin
            a_q   <= '0;
            b_q   <= '0;
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (load_i) begin
            a_q   <= a_i;
            b_q   <= b_i;
            acc_q <= '0;
            rem_q <= '0;
            quo_q <= '0;
        end else if (step_i) begin
            case (op_i)
                OP_MUL: begin
                    acc_q <= sum[RW-1:0];
                    a_q   <= a_q >> 1;
                end
                OP_DIV: begin
                    rem_q <= rem_new;
                    quo_q <= quo_new;
                    a_q   <= a_q << 1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/calc_seq_ctrl.sv
// Calculator sequencer: accepts one command, iterates the shared datapath, returns one result.
module calc_seq_ctrl
    import calc_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clr,
    calc_seq_ctrl_if.slave bus,
    output logic           opnd_sel,
    output logic           busy
);
    localparam int RW    = res_w(WIDTH);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    op_e              op_q;
    logic [CNT_W-1:0] cnt_q;
    logic             cmd_ready_q;
    logic             res_valid_q;
    logic             res_err_q;
    logic             opnd_sel_q;
    logic [RW-1:0]    res_data_q;

    logic             accept;
    logic             dp_step;
    logic             mul_next_bit;
    logic             b_zero;
    logic [RW-1:0]    dp_result;

    assign accept  = (state_q == ST_IDLE) && cmd_ready_q && bus.cmd_valid && !clr;
    assign dp_step = (state_q == ST_EXEC) && !clr;

    calc_seq_datapath #(
        .WIDTH (WIDTH),
        .CNT_W (CNT_W)
    ) u_datapath (
        .clk            (clk),
        .rst_n          (rst_n),
        .clr_i          (clr),
        .load_i         (accept),
        .step_i         (dp_step),
        .op_i           (op_q),
        .cnt_i          (cnt_q),
        .opnd_sel_i     (opnd_sel_q),
        .a_i            (bus.cmd_a),
        .b_i            (bus.cmd_b),
        .mul_next_bit_o (mul_next_bit),
        .b_zero_o       (b_zero),
        .result_o       (dp_result)
    );

    // opnd_sel is registered one cycle ahead: it reflects the multiplier bit of the step about to run.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            opnd_sel_q  <= 1'b0;
        end else if (clr) begin
            state_q     <= ST_IDLE;
            op_q        <= OP_ADD;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b1;
            res_valid_q <= 1'b0;
            res_err_q   <= 1'b0;
            res_data_q  <= '0;
            opnd_sel_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_EXEC;
                        op_q        <= op_e'(bus.cmd_op);
                        cnt_q       <= '0;
                        cmd_ready_q <= 1'b0;
                        case (op_e'(bus.cmd_op))
                            OP_MUL:  opnd_sel_q <= bus.cmd_a[0];
                            OP_DIV:  opnd_sel_q <= (bus.cmd_b != '0);
                            default: opnd_sel_q <= 1'b1;
                        endcase
                    end
                end
                ST_EXEC: begin
                    if ((op_q == OP_MUL || (op_q == OP_DIV && !b_zero)) && cnt_q != CNT_LAST) begin
                        cnt_q      <= cnt_q + CNT_W'(1);
                        opnd_sel_q <= (op_q == OP_MUL) ? mul_next_bit : 1'b1;
                    end else begin
                        state_q     <= ST_DONE;
                        res_valid_q <= 1'b1;
                        opnd_sel_q  <= 1'b0;
                        res_data_q  <= (op_q == OP_DIV && b_zero) ? '1 : dp_result;
                        res_err_q   <= (op_q == OP_DIV && b_zero);
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state_q     <= ST_IDLE;
                        res_valid_q <= 1'b0;
                        res_err_q   <= 1'b0;
                        cmd_ready_q <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready = cmd_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_err   = res_err_q;
    assign opnd_sel      = opnd_sel_q;
    assign busy          = (state_q != ST_IDLE);

endmodule

// File: tb/tb_calc_seq_ctrl.sv
// Randomised and directed self-checking bench for calc_seq_ctrl against an arithmetic reference model.
module tb_calc_seq_ctrl;
    import calc_pkg::*;

    localparam int WIDTH = 8;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic clr   = 1'b0;
    logic opnd_sel;
    logic busy;

    int checkCount = 0;
    int failCount  = 0;

    calc_seq_ctrl_if #(.WIDTH(WIDTH)) bus ();

    calc_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (clr),
        .bus      (bus.slave),
        .opnd_sel (opnd_sel),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain arithmetic on the operands, plus the expected latency in edges.
    task automatic modelResult(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                               output logic [15:0] data, output logic err, output int lat);
        err = 1'b0;
        lat = 1;
        case (op)
            2'd0: data = 16'(int'(a) + int'(b));
            2'd1: data = 16'(int'(a) - int'(b));
            2'd2: begin
                data = 16'(int'(a) * int'(b));
                lat  = WIDTH;
            end
            default: begin
                if (b == 8'd0) begin
                    data = 16'hFFFF;
                    err  = 1'b1;
                end else begin
                    data = {8'(a % b), 8'(a / b)};
                    lat  = WIDTH;
                end
            end
        endcase
    endtask

    task automatic sendCmd(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        @(negedge clk);
        checkOutput("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'($urandom);
        bus.cmd_a     = 8'($urandom);
        bus.cmd_b     = 8'($urandom);
    endtask

    task automatic collectResult(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input int hold, input bit pokeCmd);
        logic [15:0] expData;
        logic        expErr;
        int          expLat;
        int          lat;
        modelResult(op, a, b, expData, expErr, expLat);
        lat = 0;
        while (bus.res_valid !== 1'b1 && lat < 4 * WIDTH) begin
            checkOutput("busy_exec", busy, 1);
            if (op == 2'd2)
                checkOutput("opsel_mul", opnd_sel, (lat < WIDTH) ? a[lat] : 1'b0);
            else if (op == 2'd3 && b != 8'd0)
                checkOutput("opsel_div", opnd_sel, 1);
            @(posedge clk);
            #1;
            lat++;
        end
        checkOutput("latency", lat, expLat);
        checkOutput("res_valid", bus.res_valid, 1);
        checkOutput("res_data", bus.res_data, expData);
        checkOutput("res_err", bus.res_err, expErr);
        checkOutput("cmd_ready_done", bus.cmd_ready, 0);
        checkOutput("opsel_done", opnd_sel, 0);
        checkOutput("busy_done", busy, 1);
        for (int i = 0; i < hold; i++) begin
            if (pokeCmd && i == 0) bus.cmd_valid = 1'b1;
            @(posedge clk);
            #1;
            bus.cmd_valid = 1'b0;
            checkOutput("hold_valid", bus.res_valid, 1);
            checkOutput("hold_data", bus.res_data, expData);
            checkOutput("hold_err", bus.res_err, expErr);
            checkOutput("hold_cmd_ready", bus.cmd_ready, 0);
        end
        bus.res_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.res_ready = 1'b0;
        checkOutput("handoff_valid", bus.res_valid, 0);
        checkOutput("handoff_cmd_ready", bus.cmd_ready, 1);
        checkOutput("handoff_err", bus.res_err, 0);
        checkOutput("handoff_data_held", bus.res_data, expData);
        checkOutput("handoff_busy", busy, 0);
    endtask

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input int hold, input bit pokeCmd);
        sendCmd(op, a, b);
        collectResult(op, a, b, hold, pokeCmd);
    endtask

    task automatic checkResetValues(input string tag);
        checkOutput({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        checkOutput({tag, "_res_valid"}, bus.res_valid, 0);
        checkOutput({tag, "_res_data"}, bus.res_data, 0);
        checkOutput({tag, "_res_err"}, bus.res_err, 0);
        checkOutput({tag, "_opnd_sel"}, opnd_sel, 0);
        checkOutput({tag, "_busy"}, busy, 0);
    endtask

    initial begin
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        bit         sawValid;

        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 8'd0;
        bus.cmd_b     = 8'd0;
        bus.res_ready = 1'b0;

        #12;
        checkResetValues("reset");
        @(negedge clk);
        rst_n = 1'b1;

        applyStimulus(2'd0, 8'd200, 8'd100, 0, 1'b0);
        applyStimulus(2'd1, 8'd5,   8'd7,   0, 1'b0);
        applyStimulus(2'd1, 8'd7,   8'd5,   0, 1'b0);
        applyStimulus(2'd2, 8'd255, 8'd255, 0, 1'b0);
        applyStimulus(2'd2, 8'd0,   8'h77,  0, 1'b0);
        applyStimulus(2'd3, 8'd100, 8'd7,   0, 1'b0);
        applyStimulus(2'd3, 8'd9,   8'd0,   0, 1'b0);
        applyStimulus(2'd2, 8'd12,  8'd13,  5, 1'b1);

        for (int n = 0; n < 40; n++) begin
            op = 2'($urandom_range(0, 3));
            a  = 8'($urandom);
            b  = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
            applyStimulus(op, a, b, int'($urandom_range(0, 3)), 1'(n % 2));
        end

        $display("[TB] async reset in the middle of a divide");
        sendCmd(2'd3, 8'd200, 8'd9);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        checkResetValues("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        sawValid = 1'b0;
        repeat (2 * WIDTH) begin
            @(posedge clk);
            #1;
            if (bus.res_valid === 1'b1) sawValid = 1'b1;
        end
        checkOutput("midreset_no_result", sawValid, 0);
        checkOutput("midreset_idle", busy, 0);

        $display("[TB] clr during a multiply");
        sendCmd(2'd2, 8'd77, 8'd91);
        repeat (2) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        checkResetValues("clr_mul");
        applyStimulus(2'd0, 8'd1, 8'd1, 0, 1'b0);

        $display("[TB] clr coinciding with a command");
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_a     = 8'd3;
        bus.cmd_b     = 8'd4;
        clr           = 1'b1;
        @(posedge clk);
        #1;
        bus.cmd_valid = 1'b0;
        clr           = 1'b0;
        checkResetValues("clr_cmd");
        repeat (3) @(posedge clk);
        #1;
        checkOutput("clr_cmd_no_result", bus.res_valid, 0);
        checkOutput("clr_cmd_idle", busy, 0);

        applyStimulus(2'd2, 8'd3, 8'd250, 1, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule

// File: doc/calc_seq_ctrl.md
Name: calc_seq_ctrl

Overview:
Sequencing controller for the calculator datapath. It accepts one command (opcode plus two operands) over a valid/ready handshake and drives the operand-select mux and the shared adder. ADD/SUB complete in a single cycle; MUL uses iterative shift-add and DIV uses restoring division. It returns one result over a second valid/ready handshake and sits between the keypad/command decoder and the display formatter.

Parameters:
WIDTH, 8, operand width in bits (≥2); result width is 2*WIDTH

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
clr  input  1  synchronous abort; returns to IDLE, drops any in-flight command
cmd_valid  input  1  command present
cmd_ready  output  1  controller can accept a command
cmd_op  input  2  0=ADD 1=SUB 2=MUL 3=DIV
cmd_a  input  WIDTH  operand A (unsigned)
cmd_b  input  WIDTH  operand B (unsigned)
res_valid  output  1  result present
res_ready  input  1  consumer takes result
res_data  output  2*WIDTH  result
res_err  output  1  divide-by-zero flag, qualified by res_valid
opnd_sel  output  1  operand mux select to the shared adder (0=accumulator/A path, 1=B path)
busy  output  1  high in EXEC or DONE

Behaviour:
- Reset (rst_n low, async): state=IDLE, cmd_ready=1, res_valid=0, res_data=0, res_err=0, opnd_sel=0, busy=0. Internal A/B/accumulator/counter are cleared.
- States are IDLE, EXEC, DONE.
- IDLE:
  - cmd_ready=1.
  - A handshake (cmd_valid&cmd_ready at an edge) latches op, A and B, clears the counter, and moves to EXEC.
- EXEC, ADD: one cycle. res_data = zero-extended A+B; carry lands in bit WIDTH. Then DONE.
- EXEC, SUB: one cycle. res_data = A−B as a 2*WIDTH two's-complement value (sign-extended). Then DONE.
- EXEC, MUL: WIDTH cycles, counter 0..WIDTH-1.
  - Each cycle: if multiplier LSB=1, accumulator += B<<counter through the shared adder (opnd_sel=1 on add cycles, else 0). Then shift the multiplier right.
  - At counter=WIDTH-1, move to DONE. res_data = unsigned product.
- EXEC, DIV with B≠0: WIDTH cycles of restoring division, MSB first.
  - Shift the remainder left, bring in the next bit of A, trial-subtract B (opnd_sel=1), restore if negative, set the quotient bit.
  - res_data = {remainder[WIDTH-1:0], quotient[WIDTH-1:0]}.
- EXEC, DIV with B=0: one cycle. res_data = all ones, res_err=1, then DONE.
- Latency, from the acceptance edge to the edge that raises res_valid:
  - ADD/SUB/DIV-by-0: 1.
  - MUL/DIV: WIDTH.
- DONE:
  - res_valid=1; res_data and res_err are registered and held stable until the handshake.
  - On res_valid&res_ready, go to IDLE. res_valid=0 next cycle, res_err is cleared, and res_data holds its last value.
  - A new command cannot be accepted in the same cycle as result hand-off: cmd_ready rises one cycle after.
- Backpressure: res_ready low keeps DONE indefinitely; cmd_ready stays 0.
- clr:
  - Has priority over all transitions in every state and outputs the reset values next edge.
  - A clr coinciding with a command or result handshake discards it.
  - cmd_valid with clr=1 is not accepted.
- Reset mid-operation: everything is discarded immediately (async); no result is produced.
- busy = (state≠IDLE). opnd_sel=0 outside EXEC.
- Operand inputs are sampled only at acceptance; later changes on cmd_a/cmd_b have no effect.

Decomposition:
- Shared package calc_pkg holds:
  - opcode constants OP_ADD/OP_SUB/OP_MUL/OP_DIV (2-bit);
  - state encoding ST_IDLE/ST_EXEC/ST_DONE;
  - a RES_W=2*WIDTH helper.
- One natural sub-module: calc_seq_datapath. It contains the A/B/accumulator/quotient registers, the 2:1 operand-select muxes and the shared adder/subtractor.
- calc_seq_ctrl keeps the FSM, counter and handshakes, and drives the datapath enables and opnd_sel.

Test Plan:
- WIDTH=8, ADD 200+100 → res_valid 1 edge after accept; res_data=0x012C, res_err=0; cmd_ready high one cycle after hand-off.
- SUB 5−7 → res_data=0xFFFE. SUB 7−5 → 0x0002. Both latency 1.
- MUL 255×255 → res_valid exactly 8 edges after accept, res_data=0xFE01. MUL 0×77 → 0x0000 after 8 edges.
- DIV 100/7 → res_data=0x020E (r=2, q=14) after 8 edges. DIV 9/0 → 1 edge, res_data=0xFFFF, res_err=1.
- Backpressure: MUL 12×13, res_ready low 5 cycles → res_valid stays 1, res_data=0x009C stable, cmd_ready=0; a cmd_valid pulse meanwhile is ignored.
- Abort: rst_n pulsed low mid-DIV → outputs go to reset values immediately, no res_valid. Separately, clr at cycle 3 of MUL → IDLE next edge, cmd_ready=1, next ADD 1+1 → 0x0002.
